neuron_layer_ctrl: RTL and testbench

Sequences one shared fixed-point neuron datapath (Q8.8 MAC, bias add, sigmoid LUT) through all neurons of a fully connected layer.
For each neuron it clears the MAC, streams NUM_INPUTS pixel/weight pairs from synchronous memories, waits for the sigmoid result, and writes the Q0.8 activation to an activation buffer.
It sits between the top-level inference FSM (start/done) and the pixel RAM, weight ROM, bias ROM, neuron and activation RAM.

---
 rtl/neuron_layer_ctrl_if.sv | 88 ++++++++
 rtl/neuron_layer_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_neuron_layer_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_layer_ctrl_if.sv
// -----------------------------------------------------------------------------
// neuron_layer_ctrl_if
//
// Bundles every non-clock/reset signal of the layer controller: the run
// handshake from the inference FSM, the pixel RAM / weight ROM / bias ROM read
// buses, the shared neuron datapath connection and the activation RAM write
// port.
//
// Modports:
//   master - the layer controller (drives addresses, neuron controls, writes)
//   slave  - the surroundings (memories, neuron, inference FSM)
//
// Signals:
//   start/busy/done/err        run handshake and sticky sigmoid-timeout flag
//   pix_addr/pix_data          pixel RAM, 1-cycle read latency, Q8.8 data
//   w_addr/w_data              weight ROM, 1-cycle read latency, Q8.8 data
//   b_addr/b_data              bias ROM, data stable for the whole pass
//   n_clr/n_inp_ready          neuron clear pulse and beat valid
//   n_inp_data/n_weight/n_bias operands forwarded to the neuron
//   n_sig_out/n_sig_ready      neuron sigmoid result and its strobe
//   act_we/act_addr/act_wdata  activation RAM write port (Q0.8)
//   pred_class                 argmax of the run, only with ARGMAX_EN defined
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface neuron_layer_ctrl_if #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10
);
  localparam int PA_W = $clog2(NUM_INPUTS);
  localparam int WA_W = $clog2(NUM_INPUTS * NUM_NEURONS);
  localparam int NA_W = $clog2(NUM_NEURONS);

  logic            start;
  logic            busy;
  logic            done;
  logic            err;

  logic [PA_W-1:0] pix_addr;
  logic [15:0]     pix_data;
  logic [WA_W-1:0] w_addr;
  logic [15:0]     w_data;
  logic [NA_W-1:0] b_addr;
  logic [15:0]     b_data;

  logic            n_clr;
  logic            n_inp_ready;
  logic [15:0]     n_inp_data;
  logic [15:0]     n_weight;
  logic [15:0]     n_bias;
  logic [7:0]      n_sig_out;
  logic            n_sig_ready;

  logic            act_we;
  logic [NA_W-1:0] act_addr;
  logic [7:0]      act_wdata;

`ifdef ARGMAX_EN
  logic [NA_W-1:0] pred_class;
`endif

  modport master (
`ifdef ARGMAX_EN
    output pred_class,
`endif
    input  start,
    output busy, done, err,
    output pix_addr, w_addr, b_addr,
    input  pix_data, w_data, b_data,
    output n_clr, n_inp_ready, n_inp_data, n_weight, n_bias,
    input  n_sig_out, n_sig_ready,
    output act_we, act_addr, act_wdata
  );

  modport slave (
`ifdef ARGMAX_EN
    input  pred_class,
`endif
    output start,
    input  busy, done, err,
    input  pix_addr, w_addr, b_addr,
    output pix_data, w_data, b_data,
    input  n_clr, n_inp_ready, n_inp_data, n_weight, n_bias,
    output n_sig_out, n_sig_ready,
    input  act_we, act_addr, act_wdata
  );

endinterface

// File: rtl/neuron_layer_ctrl.sv
// -----------------------------------------------------------------------------
// neuron_layer_ctrl
//
// Walks one shared fixed-point neuron (Q8.8 MAC, bias add, sigmoid LUT)
// through every neuron of a fully connected layer. Per neuron it clears the
// MAC, streams NUM_INPUTS pixel/weight pairs out of the synchronous memories,
// waits for the sigmoid strobe and writes the Q0.8 activation to the
// activation buffer. Nominal period per neuron is NUM_INPUTS+6 cycles:
// CLR(1) + STREAM(NUM_INPUTS+1) + WAIT_SIG(3) + WRITE(1).
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-high; aborts a run with no write and no done
//   bus    neuron_layer_ctrl_if.master (handshake, memory reads, neuron,
//          activation write; see the interface file for the signal list)
//
// Optional feature (macro ARGMAX_EN):
//   defined   - tracks the largest activation of the run (strict >, so the
//               lower index wins ties) and presents its index on pred_class
//               from the FINISH cycle of a completed run
//   undefined - pred_class and the comparator do not exist
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module neuron_layer_ctrl #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int TIMEOUT     = 15,
  parameter int PA_W        = $clog2(NUM_INPUTS),
  parameter int WA_W        = $clog2(NUM_INPUTS * NUM_NEURONS),
  parameter int NA_W        = $clog2(NUM_NEURONS)
) (
  input  logic                clk,
  input  logic                reset,
  neuron_layer_ctrl_if.master bus
);

  // Beat counter must also hold NUM_INPUTS for the drain cycle.
  localparam int BT_W = $clog2(NUM_INPUTS + 1);
  // Timeout counter must reach TIMEOUT+1 to detect expiry.
  localparam int TC_W = $clog2(TIMEOUT + 2);
  localparam int ACT_W = 8;

  localparam logic [BT_W-1:0] LAST_BEAT = BT_W'(NUM_INPUTS);
  localparam logic [NA_W-1:0] LAST_N    = NA_W'(NUM_NEURONS - 1);
  localparam logic [TC_W-1:0] TC_MAX    = TC_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_WAIT_SIG,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t           state;
  logic [BT_W-1:0]  beat;
  logic [NA_W-1:0]  neuron;
  logic [TC_W-1:0]  tcnt;
  logic [WA_W-1:0]  w_addr_p0;
  logic             vld_p1;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             n_clr_r;
  logic             act_we_r;
  logic [NA_W-1:0]  act_addr_r;
  logic [ACT_W-1:0] act_wdata_r;

`ifdef ARGMAX_EN
  logic [ACT_W-1:0] max_val;
  logic [NA_W-1:0]  max_idx;
  logic [NA_W-1:0]  pred_r;

  // Strict comparison: an equal later activation never displaces the
  // earlier (lower-index) winner.
  function automatic logic beats_max(input logic [ACT_W-1:0] cand,
                                     input logic [ACT_W-1:0] best);
    return cand > best;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      beat        <= '0;
      neuron      <= '0;
      tcnt        <= '0;
      w_addr_p0   <= '0;
      vld_p1      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      n_clr_r     <= 1'b0;
      act_we_r    <= 1'b0;
      act_addr_r  <= '0;
      act_wdata_r <= '0;
`ifdef ARGMAX_EN
      max_val     <= '0;
      max_idx     <= '0;
      pred_r      <= '0;
`endif
    end else begin
      // Single-cycle strobes default low every cycle.
      n_clr_r  <= 1'b0;
      done_r   <= 1'b0;
      act_we_r <= 1'b0;
      vld_p1   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_CLR;
            busy_r    <= 1'b1;
            err_r     <= 1'b0;
            neuron    <= '0;
            beat      <= '0;
            // The weight address only wraps here, at the start of a run.
            w_addr_p0 <= '0;
            n_clr_r   <= 1'b1;
`ifdef ARGMAX_EN
            max_val   <= '0;
            max_idx   <= '0;
`endif
          end
        end

        S_CLR: begin
          state <= S_STREAM;
        end

        // Stage p0: address issue (beat < NUM_INPUTS); stage p1: read data
        // returns one cycle later together with vld_p1.
        S_STREAM: begin
          if (beat != LAST_BEAT) begin
            beat      <= beat + 1'b1;
            w_addr_p0 <= w_addr_p0 + 1'b1;
            vld_p1    <= 1'b1;
          end else begin
            // Drain cycle done: last beat has been presented to the neuron.
            state <= S_WAIT_SIG;
            tcnt  <= TC_W'(1);
          end
        end

        S_WAIT_SIG: begin
          if (bus.n_sig_ready) begin
            state       <= S_WRITE;
            act_we_r    <= 1'b1;
            act_addr_r  <= neuron;
            act_wdata_r <= bus.n_sig_out;
`ifdef ARGMAX_EN
            if (beats_max(bus.n_sig_out, max_val)) begin
              max_val <= bus.n_sig_out;
              max_idx <= neuron;
            end
`endif
          end else if (tcnt > TC_MAX) begin
            // Sigmoid never arrived: abort the run, keep pred_class as is.
            state  <= S_FINISH;
            err_r  <= 1'b1;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_WRITE: begin
          if (neuron == LAST_N) begin
            state  <= S_FINISH;
            done_r <= 1'b1;
            busy_r <= 1'b0;
`ifdef ARGMAX_EN
            pred_r <= max_idx;
`endif
          end else begin
            state   <= S_CLR;
            neuron  <= neuron + 1'b1;
            beat    <= '0;
            n_clr_r <= 1'b1;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.err         = err_r;

  // pix_addr follows the beat counter; in the drain cycle its value is unused.
  assign bus.pix_addr    = beat[PA_W-1:0];
  assign bus.w_addr      = w_addr_p0;
  assign bus.b_addr      = neuron;

  assign bus.n_clr       = n_clr_r;
  assign bus.n_inp_ready = vld_p1;
  assign bus.n_inp_data  = bus.pix_data;
  assign bus.n_weight    = bus.w_data;
  assign bus.n_bias      = bus.b_data;

  assign bus.act_we      = act_we_r;
  assign bus.act_addr    = act_addr_r;
  assign bus.act_wdata   = act_wdata_r;

`ifdef ARGMAX_EN
  assign bus.pred_class  = pred_r;
`endif

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_neuron_layer_ctrl
//
// Bench for neuron_layer_ctrl with random pixel/weight/bias memories and a
// stub neuron that really accumulates the streamed beats. A reference model
// computes each neuron's activation straight from the memory arrays and pushes
// the expected activation writes into a scoreboard queue; a monitor pops and
// compares on every act_we, and also checks the per-pass beat structure.
// Cycle numbering: "cycle n" is the clock period that ends at rising edge n.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_neuron_layer_ctrl;

  localparam int NI         = 784;
  localparam int NN         = 10;
  localparam int TO         = 15;
  localparam int PERIOD     = NI + 6;
  localparam int START_EDGE = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neuron_layer_ctrl_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) bus ();

  neuron_layer_ctrl #(
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN),
    .TIMEOUT    (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memories ----------------
  logic [15:0] pix_mem [NI];
  logic [15:0] w_mem   [NI*NN];
  logic [15:0] b_mem   [NN];

  always @(posedge clk) begin
    bus.pix_data <= (int'(bus.pix_addr) < NI) ? pix_mem[bus.pix_addr] : 16'h0;
    bus.w_data   <= (int'(bus.w_addr) < NI*NN) ? w_mem[bus.w_addr] : 16'h0;
  end
  assign bus.b_data = (int'(bus.b_addr) < NN) ? b_mem[bus.b_addr] : 16'h0;

  task automatic fill_mems();
    for (int i = 0; i < NI; i++)    pix_mem[i] = 16'($urandom);
    for (int i = 0; i < NI*NN; i++) w_mem[i]   = 16'($urandom);
    for (int i = 0; i < NN; i++)    b_mem[i]   = 16'($urandom);
  endtask

  // ---------------- stub neuron ----------------
  logic [7:0] forced [NN];
  bit         force_act = 1'b0;
  bit         stall_en  = 1'b0;
  int         stall_n   = 0;

  function automatic logic [7:0] squash(input longint dot, input logic [15:0] b);
    longint v;
    v = (dot >>> 8) + longint'($signed(b));
    return v[7:0] ^ v[15:8];
  endfunction

  longint acc   = 0;
  logic   vld_d = 1'b0;
  logic   fire  = 1'b0;

  initial begin
    bus.n_sig_ready = 1'b0;
    bus.n_sig_out   = 8'h0;
  end

  // Result strobe comes three cycles after the last beat (third WAIT_SIG
  // cycle). Stray strobes are injected early in STREAM and must be ignored.
  always @(posedge clk) begin
    vld_d <= bus.n_inp_ready;
    fire  <= vld_d && !bus.n_inp_ready;
    if (bus.n_clr)
      acc <= 0;
    else if (bus.n_inp_ready)
      acc <= acc + longint'($signed(bus.n_inp_data)) * longint'($signed(bus.n_weight));
    bus.n_sig_ready <= 1'b0;
    if (fire && !(stall_en && int'(bus.b_addr) == stall_n)) begin
      bus.n_sig_ready <= 1'b1;
      bus.n_sig_out   <= force_act ? forced[bus.b_addr] : squash(acc, bus.n_bias);
    end else if (bus.n_inp_ready && int'(bus.pix_addr) < NI - 10 &&
                 $urandom_range(0, 63) == 0) begin
      bus.n_sig_ready <= 1'b1;
      bus.n_sig_out   <= 8'($urandom);
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int         addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] ref_vals [NN];
  int         next_pred = 0;
  int         cur_pred  = 0;

  function automatic logic [7:0] ref_act(input int n);
    longint dot = 0;
    if (force_act) return forced[n];
    for (int i = 0; i < NI; i++)
      dot += longint'($signed(pix_mem[i])) * longint'($signed(w_mem[n*NI + i]));
    return squash(dot, b_mem[n]);
  endfunction

  task automatic issue_run(input int upto);
    int best_v;
    for (int n = 0; n < NN; n++) ref_vals[n] = ref_act(n);
    for (int n = 0; n < upto; n++) begin
      exp_t e;
      e.addr = n;
      e.data = ref_vals[n];
      sb.push_back(e);
    end
    best_v    = -1;
    next_pred = 0;
    for (int n = 0; n < NN; n++)
      if (int'(ref_vals[n]) > best_v) begin
        best_v    = int'(ref_vals[n]);
        next_pred = n;
      end
  endtask

  // ---------------- monitor ----------------
  int          run_len = 0, exp_pix = 0, exp_w = 0, pass_idx = 0, clr_cnt = 0;
  int          done_cnt = 0, act_cnt = 0;
  logic        prev_vld = 1'b0, prev_busy = 1'b0;
  int          prev_pix = 0, prev_w = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      run_len   = 0;
      clr_cnt   = 0;
      prev_vld  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.act_we) begin
        act_cnt++;
        if (sb.size() == 0) begin
          check("act_we_unexpected", int'(bus.act_addr), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("act_addr", int'(bus.act_addr), e.addr);
          check("act_wdata", int'(bus.act_wdata), int'(e.data));
        end
      end
      if (bus.busy && !prev_busy) begin
        exp_w    = 0;
        pass_idx = 0;
        clr_cnt  = 0;
      end
      if (bus.n_clr) clr_cnt++;
      if (bus.n_inp_ready) begin
        if (!prev_vld) begin
          check("clr_before_pass", clr_cnt, 1);
          check("b_addr_pass", int'(bus.b_addr), pass_idx);
          check("n_bias_pass", int'(bus.n_bias), int'(b_mem[pass_idx]));
          run_len = 0;
          exp_pix = 0;
        end
        check("pix_addr_seq", prev_pix, exp_pix);
        check("w_addr_seq", prev_w, exp_w);
        check("n_inp_data", int'(bus.n_inp_data), int'(pix_mem[exp_pix]));
        check("n_weight", int'(bus.n_weight), int'(w_mem[exp_w]));
        exp_pix++;
        exp_w++;
        run_len++;
      end else if (prev_vld) begin
        check("beats_per_pass", run_len, NI);
        pass_idx++;
        clr_cnt = 0;
      end
      prev_vld  = bus.n_inp_ready;
      prev_busy = bus.busy;
      prev_pix  = int'(bus.pix_addr);
      prev_w    = int'(bus.w_addr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_zero(input string tag);
    check({tag, "_busy"},      int'(bus.busy), 0);
    check({tag, "_done"},      int'(bus.done), 0);
    check({tag, "_err"},       int'(bus.err), 0);
    check({tag, "_pix_addr"},  int'(bus.pix_addr), 0);
    check({tag, "_w_addr"},    int'(bus.w_addr), 0);
    check({tag, "_b_addr"},    int'(bus.b_addr), 0);
    check({tag, "_n_clr"},     int'(bus.n_clr), 0);
    check({tag, "_inp_ready"}, int'(bus.n_inp_ready), 0);
    check({tag, "_act_we"},    int'(bus.act_we), 0);
    check({tag, "_act_addr"},  int'(bus.act_addr), 0);
    check({tag, "_act_wdata"}, int'(bus.act_wdata), 0);
`ifdef ARGMAX_EN
    check({tag, "_pred"},      int'(bus.pred_class), 0);
`endif
  endtask

  // Called at a negedge; start is sampled at the next edge. Returns that edge.
  task automatic do_start(output int k);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = cyc;
    check("accept_busy", int'(bus.busy), 1);
    check("accept_err", int'(bus.err), 0);
    check("accept_n_clr", int'(bus.n_clr), 1);
  endtask

  // Returns the cycle number in which done is high, or -1 on expiry.
  task automatic wait_done(input int budget, input bit spam, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = cyc + 1;
        break;
      end
      if (spam) bus.start = ($urandom_range(0, 40) == 0);
    end
    bus.start = 1'b0;
    if (seen < 0) begin
      checks++;
      errors++;
      $display("FAIL done_wait: no done within %0d cycles", budget);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, seen, acts0, dones0;
    bus.start = 1'b0;
    forced = '{8'd10, 8'd200, 8'd37, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    fill_mems();

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Run A: nominal timing, with start spammed while busy.
    issue_run(NN);
    while (cyc < START_EDGE - 1) @(negedge clk);
    acts0 = act_cnt;
    do_start(k);
    check("run_a_start_edge", k, START_EDGE);
    wait_done(NN*PERIOD + 100, 1'b1, seen);
    check("run_a_done_cycle", seen, START_EDGE + 1 + NN*PERIOD);
    check("run_a_busy_at_done", int'(bus.busy), 0);
    check("run_a_err", int'(bus.err), 0);
    check("run_a_writes", act_cnt - acts0, NN);
    check("run_a_sb_empty", sb.size(), 0);
`ifdef ARGMAX_EN
    check("run_a_pred", int'(bus.pred_class), next_pred);
    cur_pred = next_pred;
`endif

    // Run C: started the cycle after done; neuron 3 never answers.
    stall_en = 1'b1;
    stall_n  = 3;
    issue_run(3);
    @(negedge clk);
    acts0 = act_cnt;
    do_start(k);
    wait_done(4*PERIOD + 100, 1'b0, seen);
    check("timeout_done_cycle", seen, k + 1 + 3*PERIOD + NI + 18);
    check("timeout_err", int'(bus.err), 1);
    check("timeout_writes", act_cnt - acts0, 3);
    check("timeout_sb_empty", sb.size(), 0);
`ifdef ARGMAX_EN
    check("timeout_pred_held", int'(bus.pred_class), cur_pred);
`endif
    repeat (3) @(negedge clk);
    check("err_sticky", int'(bus.err), 1);
    check("done_single_pulse", int'(bus.done), 0);
    stall_en = 1'b0;

    // Run D: err clears on the new start; async reset mid-STREAM of neuron 5.
    issue_run(NN);
    do_start(k);
    seen = -1;
    for (int i = 0; i < 6*PERIOD; i++) begin
      @(negedge clk);
      if (int'(bus.b_addr) == 5 && bus.n_inp_ready && int'(bus.pix_addr) == 300) begin
        seen = i;
        break;
      end
    end
    if (seen < 0) begin
      checks++;
      errors++;
      $display("FAIL reach_neuron5: stream of neuron 5 not reached");
    end
    #2 reset = 1'b1;
    #1 check_zero("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cur_pred = 0;
    dones0 = done_cnt;
    acts0  = act_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - dones0, 0);
    check("abort_no_write", act_cnt - acts0, 0);

    // Run E: clean run from neuron 0 on fresh contents.
    fill_mems();
`ifdef ARGMAX_EN
    force_act = 1'b1;
`endif
    issue_run(NN);
    acts0 = act_cnt;
    do_start(k);
    wait_done(NN*PERIOD + 100, 1'b0, seen);
    check("run_e_done_cycle", seen, k + 1 + NN*PERIOD);
    check("run_e_err", int'(bus.err), 0);
    check("run_e_writes", act_cnt - acts0, NN);
    check("run_e_sb_empty", sb.size(), 0);
`ifdef ARGMAX_EN
    check("run_e_pred", int'(bus.pred_class), 1);
    check("run_e_pred_model", next_pred, int'(bus.pred_class));
`endif
    repeat (5) @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
